// File: rtl/conf_pkt_pkg.sv
// Shared constants, state encodings and head decode for the configuration
// packet responder.
package conf_pkt_pkg;

  localparam logic [15:0] CMD_WR_SEL  = 16'h9001;
  localparam logic [15:0] CMD_RD_SEL  = 16'h9002;
  localparam logic [15:0] CMD_WR_PROG = 16'h9003;
  localparam logic [15:0] CMD_RD_PROG = 16'h9004;

  localparam logic [1:0] TAG_HEAD = 2'b01;
  localparam logic [1:0] TAG_BODY = 2'b00;
  localparam logic [1:0] TAG_TAIL = 2'b10;

  localparam int SEL_BIT   = 16;
  localparam int INSTR_LSB = 48;
  localparam int ADDR_LSB  = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_SEL,
    ST_RD_SEL,
    ST_WR_PROG,
    ST_RD_PROG,
    ST_DISCARD,
    ST_RESP
  } state_e;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_BODY,
    PH_TAIL
  } resp_phase_e;

  function automatic state_e decode_cmd(input logic [15:0] cmd);
    case (cmd)
      CMD_WR_SEL:  return ST_WR_SEL;
      CMD_RD_SEL:  return ST_RD_SEL;
      CMD_WR_PROG: return ST_WR_PROG;
      CMD_RD_PROG: return ST_RD_PROG;
      default:     return ST_DISCARD;
    endcase
  endfunction

endpackage

// File: rtl/conf_pkt_responder_resp_gen.sv
// Three-word reply serializer: head on the start cycle's next edge, then body
// (payload sampled live at that edge), then tail.
module conf_resp_gen (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [47:0]  smac,
  input  logic [47:0]  dmac,
  input  logic [15:0]  cmd,
  input  logic [127:0] payload,
  output logic         data_out_valid,
  output logic [133:0] data_out,
  output logic         busy
);
  import conf_pkt_pkg::*;

  resp_phase_e phase;

  assign busy = (phase != PH_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase          <= PH_IDLE;
      data_out_valid <= 1'b0;
      data_out       <= '0;
    end else begin
      case (phase)
        PH_IDLE: begin
          if (start) begin
            data_out_valid <= 1'b1;
            data_out       <= {TAG_HEAD, 4'hf, smac, dmac, cmd, 16'h0};
            phase          <= PH_BODY;
          end else begin
            data_out_valid <= 1'b0;
            data_out       <= '0;
          end
        end
        PH_BODY: begin
          data_out <= {TAG_BODY, 4'hf, payload};
          phase    <= PH_TAIL;
        end
        PH_TAIL: begin
          data_out <= {TAG_TAIL, 4'hf, 128'h0};
          phase    <= PH_IDLE;
        end
        default: phase <= PH_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/conf_pkt_responder.sv
// Device-side configuration packet endpoint: decodes select/program packets,
// drives conf_sel and the instruction-memory port, and returns read replies.
module conf_pkt_responder #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_in_valid,
  input  logic [133:0]      data_in,
  output logic              data_out_valid,
  output logic [133:0]      data_out,
  output logic              conf_sel,
  output logic              instr_wren,
  output logic              instr_rden,
  output logic [ADDR_W-1:0] instr_addr,
  output logic [31:0]       instr_wdata,
  input  logic [31:0]       instr_rdata,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic [CNT_W-1:0]  reject_cnt
);
  import conf_pkt_pkg::*;

  state_e            state;
  state_e            head_state;
  logic              first_seen;
  logic [15:0]       cmd_q;
  logic [47:0]       dmac_q;
  logic [47:0]       smac_q;
  logic              resp_start;
  logic              resp_busy;
  logic              rd_pending;
  logic [31:0]       rdata_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [127:0]      resp_payload;
  logic [1:0]        tag;
  logic              is_head;
  logic              is_word;
  logic              is_tail;
  logic              drop_inc;
  logic              reject_inc;
  logic [ADDR_W-1:0] word_addr;
  logic [31:0]       word_instr;
  logic              unused_bits;

  assign tag        = data_in[133:132];
  assign is_head    = data_in_valid && (tag == TAG_HEAD);
  assign is_tail    = data_in_valid && (tag == TAG_TAIL);
  assign is_word    = is_tail || (data_in_valid && (tag == TAG_BODY));
  assign head_state = decode_cmd(data_in[31:16]);
  assign word_addr  = data_in[ADDR_LSB +: ADDR_W];
  assign word_instr = data_in[INSTR_LSB +: 32];
  assign unused_bits = &{1'b0, data_in[131:128], data_in[15:0]};

  // A head while replying is dropped whole; the reply in flight is untouched.
  assign drop_inc   = is_head && ((state == ST_RESP) || (head_state == ST_DISCARD));
  assign reject_inc = is_word && (state == ST_WR_PROG) && !conf_sel;

  // rdata arrives the cycle after rden; bypass the capture register when the
  // body is emitted in that same cycle (head+tail read packets).
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    resp_payload = '0;
    if (cmd_q == CMD_RD_PROG) begin
      resp_payload[INSTR_LSB +: 32] = rd_pending ? instr_rdata : rdata_q;
      resp_payload[ADDR_LSB +: 16]  = 16'(rd_addr_q);
    end else begin
      resp_payload[SEL_BIT] = conf_sel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      first_seen  <= 1'b0;
      cmd_q       <= '0;
      dmac_q      <= '0;
      smac_q      <= '0;
      conf_sel    <= 1'b1;
      instr_wren  <= 1'b0;
      instr_rden  <= 1'b0;
      instr_addr  <= '0;
      instr_wdata <= '0;
      resp_start  <= 1'b0;
      rd_pending  <= 1'b0;
      rdata_q     <= '0;
      rd_addr_q   <= '0;
      drop_cnt    <= '0;
      reject_cnt  <= '0;
    end else begin
      instr_wren <= 1'b0;
      instr_rden <= 1'b0;
      resp_start <= 1'b0;
      rd_pending <= instr_rden;
      if (rd_pending) rdata_q <= instr_rdata;

      if (drop_inc && (drop_cnt != '1))     drop_cnt   <= drop_cnt + 1'b1;
      if (reject_inc && (reject_cnt != '1)) reject_cnt <= reject_cnt + 1'b1;

      if (state == ST_RESP) begin
        if (!resp_start && !resp_busy) state <= ST_IDLE;
      end else if (is_head) begin
        // Also aborts a packet whose tail never came.
        state      <= head_state;
        first_seen <= 1'b0;
        cmd_q      <= data_in[31:16];
        dmac_q     <= data_in[127:80];
        smac_q     <= data_in[79:32];
      end else if (is_word && (state != ST_IDLE)) begin
        first_seen <= 1'b1;
        case (state)
          ST_WR_SEL: if (!first_seen) conf_sel <= data_in[SEL_BIT];
          ST_WR_PROG: begin
            if (conf_sel) begin
              instr_wren  <= 1'b1;
              instr_addr  <= word_addr;
              instr_wdata <= word_instr;
            end
          end
          ST_RD_PROG: begin
            if (!first_seen) begin
              instr_rden <= 1'b1;
              instr_addr <= word_addr;
              rd_addr_q  <= word_addr;
            end
          end
          default: ;
        endcase
        if (is_tail) begin
          if ((state == ST_RD_SEL) || (state == ST_RD_PROG)) begin
            state      <= ST_RESP;
            resp_start <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
      end
    end
  end

  conf_resp_gen u_resp_gen (
    .clk            (clk),
    .rst            (rst),
    .start          (resp_start),
    .smac           (smac_q),
    .dmac           (dmac_q),
    .cmd            (cmd_q),
    .payload        (resp_payload),
    .data_out_valid (data_out_valid),
    .data_out       (data_out),
    .busy           (resp_busy)
  );

endmodule

// File: tb/tb_conf_pkt_responder.sv
// Directed self-checking bench for conf_pkt_responder.
module tb_conf_pkt_responder;
  import conf_pkt_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         data_in_valid;
  logic [133:0] data_in;
  logic         data_out_valid;
  logic [133:0] data_out;
  logic         conf_sel;
  logic         instr_wren;
  logic         instr_rden;
  logic [15:0]  instr_addr;
  logic [31:0]  instr_wdata;
  logic [31:0]  instr_rdata = 32'h0;
  logic [15:0]  drop_cnt;
  logic [15:0]  reject_cnt;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mem [4];
  logic [31:0] prog_instr [3];

  localparam logic [47:0] MAC_A = 48'h1111_2222_3333;
  localparam logic [47:0] MAC_B = 48'h4444_5555_6666;

  conf_pkt_responder #(.ADDR_W(16), .CNT_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .data_in_valid  (data_in_valid),
    .data_in        (data_in),
    .data_out_valid (data_out_valid),
    .data_out       (data_out),
    .conf_sel       (conf_sel),
    .instr_wren     (instr_wren),
    .instr_rden     (instr_rden),
    .instr_addr     (instr_addr),
    .instr_wdata    (instr_wdata),
    .instr_rdata    (instr_rdata),
    .drop_cnt       (drop_cnt),
    .reject_cnt     (reject_cnt)
  );

  always #5 clk = ~clk;

  // Instruction memory with one cycle of read latency.
  always @(posedge clk) if (instr_rden) instr_rdata <= mem[instr_addr[1:0]];

  task automatic check(input string tag, input logic [133:0] obs, input logic [133:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one word for one cycle; returns #1 after the edge that accepts it.
  task automatic tick(input logic v, input logic [133:0] w);
    data_in_valid = v;
    data_in       = w;
    @(posedge clk);
    #1;
    data_in_valid = 1'b0;
    data_in       = '0;
  endtask

  function automatic logic [133:0] head_w(input logic [47:0] dmac, input logic [47:0] smac,
                                          input logic [15:0] cmd);
    return {TAG_HEAD, 4'hf, dmac, smac, cmd, 16'h0};
  endfunction

  function automatic logic [133:0] body_w(input logic [127:0] p);
    return {TAG_BODY, 4'hf, p};
  endfunction

  function automatic logic [133:0] tail_w(input logic [127:0] p);
    return {TAG_TAIL, 4'hf, p};
  endfunction

  function automatic logic [127:0] prog_p(input logic [31:0] instr, input logic [15:0] addr);
    logic [127:0] p;
    p = '0;
    p[79:48] = instr;
    p[31:16] = addr;
    return p;
  endfunction

  task automatic wr_sel(input logic sel);
    logic [127:0] p;
    p = '0;
    p[16] = sel;
    tick(1'b1, head_w(MAC_A, MAC_B, CMD_WR_SEL));
    tick(1'b1, body_w(p));
    check("wr_sel_value", 134'(conf_sel), 134'(sel));
    tick(1'b1, tail_w(128'h0));
  endtask

  task automatic wr_prog(input logic expect_wr);
    tick(1'b1, head_w(MAC_A, MAC_B, CMD_WR_PROG));
    for (int i = 0; i < 3; i++) begin
      if (i == 2) tick(1'b1, tail_w(prog_p(prog_instr[i], 16'(i))));
      else        tick(1'b1, body_w(prog_p(prog_instr[i], 16'(i))));
      check("prog_wren", 134'(instr_wren), 134'(expect_wr));
      if (expect_wr) begin
        check("prog_addr", 134'(instr_addr), 134'(i));
        check("prog_wdata", 134'(instr_wdata), 134'(prog_instr[i]));
      end
    end
    tick(1'b0, '0);
    check("prog_wren_after", 134'(instr_wren), 134'(1'b0));
  endtask

  initial begin
    mem[0] = 32'h10000537;
    mem[1] = 32'h04400593;
    mem[2] = 32'h04f00613;
    mem[3] = 32'hdeadbeef;
    prog_instr[0] = 32'h10000537;
    prog_instr[1] = 32'h04400593;
    prog_instr[2] = 32'h04f00613;
    data_in_valid = 1'b0;
    data_in       = '0;
    rst           = 1'b1;

    // Reset and idle
    repeat (3) tick(1'b0, '0);
    rst = 1'b0;
    repeat (10) tick(1'b0, '0);
    check("rst_conf_sel", 134'(conf_sel), 134'(1'b1));
    check("rst_out_valid", 134'(data_out_valid), 134'(1'b0));
    check("rst_wren", 134'(instr_wren), 134'(1'b0));
    check("rst_rden", 134'(instr_rden), 134'(1'b0));
    check("rst_drop", 134'(drop_cnt), 134'(16'h0));
    check("rst_reject", 134'(reject_cnt), 134'(16'h0));

    // Select writes
    wr_sel(1'b0);
    wr_sel(1'b1);

    // Program writes with conf_sel=1, then suppressed with conf_sel=0
    wr_prog(1'b1);
    check("reject_zero", 134'(reject_cnt), 134'(16'h0));
    wr_sel(1'b0);
    wr_prog(1'b0);
    check("reject_three", 134'(reject_cnt), 134'(16'd3));

    // Program read of address 1 (conf_sel still 0)
    tick(1'b1, head_w(MAC_A, MAC_B, CMD_RD_PROG));
    tick(1'b1, body_w(prog_p(32'h0, 16'd1)));
    check("rd_rden", 134'(instr_rden), 134'(1'b1));
    check("rd_addr", 134'(instr_addr), 134'(16'd1));
    tick(1'b1, tail_w(128'h0));
    check("rd_rden_once", 134'(instr_rden), 134'(1'b0));
    check("rd_t1_valid", 134'(data_out_valid), 134'(1'b0));
    tick(1'b0, '0);
    check("rd_t2_valid", 134'(data_out_valid), 134'(1'b1));
    check("rd_t2_head", data_out, {2'b01, 4'hf, MAC_B, MAC_A, 16'h9004, 16'h0});
    tick(1'b0, '0);
    check("rd_t3_body", data_out, {2'b00, 4'hf, 48'h0, 32'h04400593, 16'h0, 16'h0001, 16'h0});
    tick(1'b0, '0);
    check("rd_t4_tail", data_out, {2'b10, 4'hf, 128'h0});
    check("rd_t4_valid", 134'(data_out_valid), 134'(1'b1));
    tick(1'b0, '0);
    check("rd_t5_valid", 134'(data_out_valid), 134'(1'b0));

    // Unknown command is discarded
    tick(1'b1, head_w(MAC_A, MAC_B, 16'h0800));
    tick(1'b1, tail_w(128'h0));
    tick(1'b0, '0);
    tick(1'b0, '0);
    check("unk_no_out", 134'(data_out_valid), 134'(1'b0));
    check("unk_drop", 134'(drop_cnt), 134'(16'd1));

    // Select read, with a new head colliding with its response
    wr_sel(1'b1);
    tick(1'b1, head_w(MAC_A, MAC_B, CMD_RD_SEL));
    tick(1'b1, tail_w(128'h0));
    tick(1'b0, '0);
    check("rs_t2_head", data_out, {2'b01, 4'hf, MAC_B, MAC_A, 16'h9002, 16'h0});
    tick(1'b0, '0);
    check("rs_t3_body", data_out, {2'b00, 4'hf, 128'h1_0000});
    tick(1'b1, head_w(MAC_B, MAC_A, CMD_RD_SEL));
    check("rs_t4_tail", data_out, {2'b10, 4'hf, 128'h0});
    check("rs_t4_valid", 134'(data_out_valid), 134'(1'b1));
    tick(1'b1, tail_w(128'h0));
    check("rs_t5_valid", 134'(data_out_valid), 134'(1'b0));
    check("rs_drop", 134'(drop_cnt), 134'(16'd2));
    repeat (4) tick(1'b0, '0);
    check("rs_no_second", 134'(data_out_valid), 134'(1'b0));

    // Reset in the middle of a response
    wr_sel(1'b0);
    tick(1'b1, head_w(MAC_A, MAC_B, CMD_RD_SEL));
    tick(1'b1, tail_w(128'h0));
    tick(1'b0, '0);
    tick(1'b0, '0);
    check("mr_t3_valid", 134'(data_out_valid), 134'(1'b1));
    rst = 1'b1;
    #1;
    check("mr_valid_drop", 134'(data_out_valid), 134'(1'b0));
    check("mr_conf_sel", 134'(conf_sel), 134'(1'b1));
    check("mr_drop_clr", 134'(drop_cnt), 134'(16'h0));
    tick(1'b0, '0);
    rst = 1'b0;
    repeat (3) tick(1'b0, '0);
    check("mr_no_resume", 134'(data_out_valid), 134'(1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/conf_pkt_responder.md
Name: conf_pkt_responder

Overview:
- Device-side endpoint of the 134-bit configuration packet protocol.
- Sits inside um_for_cpu between the GMII-side packet input and the CPU instruction memory.
- Decodes write-sel, read-sel, write-program and read-program packets; drives conf_sel and the instruction-memory port; returns read replies as packets on the output stream.

Parameters:
- ADDR_W, 16, instruction-memory word-address width (address taken from data[16+:ADDR_W]).
- CNT_W, 16, width of the saturating drop/reject counters.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- data_in_valid  in  1  input word valid; no backpressure
- data_in  in  134  [133:132] tag (01 head, 00 body, 10 tail), [131:128] valid nibble, [127:0] payload
- data_out_valid  out  1  response word valid
- data_out  out  134  response word, same format as data_in
- conf_sel  out  1  1 = configuration mode (CPU held), 0 = CPU runs
- instr_wren  out  1  instruction write strobe
- instr_rden  out  1  instruction read strobe
- instr_addr  out  ADDR_W  instruction word address
- instr_wdata  out  32  instruction write data
- instr_rdata  in  32  read data, valid exactly 1 cycle after instr_rden
- drop_cnt  out  CNT_W  packets discarded (unknown type or arrival while busy), saturating
- reject_cnt  out  CNT_W  program-write words suppressed because conf_sel=0, saturating

Behaviour:
- Reset values: conf_sel=1; every other output 0; state IDLE.
- Head decode: cmd = data_in[31:16]. 0x9001 WR_SEL, 0x9002 RD_SEL, 0x9003 WR_PROG, 0x9004 RD_PROG. Any other cmd goes to DISCARD and increments drop_cnt.
- Capture on head: dmac = data[127:80], smac = data[79:32].
- States and transitions:
  - IDLE → WR_SEL / RD_SEL / WR_PROG / RD_PROG / DISCARD on a head word.
  - Each packet state → IDLE on the tail, except RD_* states, which go → RESP.
  - RESP → IDLE after the response tail is emitted.
- "First word" means the first non-head word, whether body or tail. A head+tail packet is legal.
- WR_SEL: conf_sel <= first word data[16], visible the cycle after that word. Later words are ignored.
- WR_PROG: every non-head word, including the tail, is a write.
  - Cycle after the word: instr_wren=1, instr_addr=data[16+:ADDR_W], instr_wdata=data[79:48].
  - Back-to-back words produce back-to-back strobes.
  - If conf_sel=0, the strobe is suppressed and reject_cnt increments per word.
- RD_SEL: the first word is ignored. Response carries the current conf_sel.
- RD_PROG:
  - First word supplies the address.
  - instr_rden pulses 1 cycle later with instr_addr set.
  - instr_rdata is registered the following cycle.
  - Reads are allowed regardless of conf_sel.
- Response timing, with tail accepted at cycle T:
  - head at T+2: {01, f, smac, dmac, cmd, 16'h0}, MACs swapped.
  - body at T+3: {00, f, payload}.
  - tail at T+4: {10, f, 128'h0}.
  - data_out_valid is high on exactly these 3 cycles.
- Response payload: RD_SEL = 128'h0 with bit16 = conf_sel. RD_PROG = {48'h0, rdata, 16'h0, addr(zero-extended to 16), 16'h0}.
- data_in_valid low mid-packet: hold state, no action.
- Head in a non-IDLE packet state (missing tail): abort the current packet with no response, then decode the new head.
- Head during RESP: the whole packet is discarded, drop_cnt +1, and the response completes unaffected.
- Tag 11 or a stray body/tail in IDLE: ignored, no counter change.
- Writes and reads wrap at 2^ADDR_W; upper address bits are ignored.
- Counters saturate at all-ones.
- Reset mid-packet or mid-response returns immediately to reset values; a partial response is not completed.

Decomposition:
- Package conf_pkt_pkg holds:
  - command constants CMD_WR_SEL/CMD_RD_SEL/CMD_WR_PROG/CMD_RD_PROG
  - tag constants TAG_HEAD=2'b01, TAG_BODY=2'b00, TAG_TAIL=2'b10
  - state enum
  - payload bit-position constants (SEL_BIT=16, INSTR_LSB=48, ADDR_LSB=16)
- One natural sub-module: conf_resp_gen, a 3-word response serializer taking {smac, dmac, cmd, payload} plus a start pulse and returning busy.

Test Plan:
- Reset, then idle 10 cycles → conf_sel=1; data_out_valid, instr_wren, instr_rden, drop_cnt and reject_cnt all 0.
- WR_SEL packet, body payload 128'h0 → conf_sel=0 the cycle after the body. Repeat with 128'h1_0000 → conf_sel=1.
- conf_sel=1, WR_PROG head + words {instr 0x10000537 addr 0}, {0x04400593 addr 1}, tail {0x04f00613 addr 2} → three consecutive wren pulses with addr 0,1,2 and matching wdata; reject_cnt stays 0.
- conf_sel=0, same WR_PROG → no wren; reject_cnt=3.
- Memory model returns 0x04400593; RD_PROG head (dmac 1111_2222_3333, smac 4444_5555_6666) + body addr 1 + tail → rden with addr=1. Response at T+2..T+4: head [127:80]=444455556666, [79:32]=111122223333, [31:16]=9004; body [79:48]=04400593, [31:16]=0001; then tail.
- Head with cmd 0x0800 → no output, drop_cnt=1. A RD_SEL head arriving at T+3 of a prior response → prior response intact, drop_cnt=2. Reset asserted at T+3 → data_out_valid drops immediately, conf_sel=1.
